// File: rtl/spi_serializer_param.sv
// SPI transmit serializer: per-frame CPOL/CPHA and slave select, busy/done handshake.
// Optional MISO capture into rx_data when SPI_SER_MISO_EN is defined.
module spi_serializer_param #(
    parameter int DATA_W    = 32,
    parameter int FRAME_W   = 24,
    parameter int DIV       = 4,
    parameter int NUM_CS    = 1,
    parameter int CSW       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  Data_Register,
    input  logic               ld,
    input  logic [1:0]         mode,
    input  logic [CSW-1:0]     cs_sel,
`ifdef SPI_SER_MISO_EN
    input  logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
`endif
    output logic               DataBit,
    output logic               SPI_clk,
    output logic [NUM_CS-1:0]  CS,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TOG_W = $clog2(2 * FRAME_W + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV - 1);
    localparam logic [TOG_W-1:0] TOG_LOAD = TOG_W'(2 * FRAME_W);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                ld_q;
    logic [CNT_W-1:0]    div_cnt;
    logic [TOG_W-1:0]    tog_left;
    logic                cpol_q;
    logic                cpha_q;
    logic [FRAME_W-1:0]  sreg;
    logic [FRAME_W-1:0]  frame;
    logic [NUM_CS-1:0]   cs_dec;
    logic                start;
    logic                tick;
    logic                leading;
    logic                last_tog;
    logic                toggle_en;
    logic                present_en;
    logic                frame_end;
    logic                data_unused;

    function automatic logic head_bit(input logic [FRAME_W-1:0] v);
        return (MSB_FIRST != 0) ? v[FRAME_W-1] : v[0];
    endfunction

    function automatic logic [FRAME_W-1:0] advance(input logic [FRAME_W-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    assign frame       = Data_Register[FRAME_W-1:0];
    assign data_unused = ^Data_Register;
    assign start       = ld & ~ld_q & (state == IDLE);
    assign tick        = (state != IDLE) && (div_cnt == '0);
    // A toggle away from the idle level is a leading edge.
    assign leading     = (SPI_clk == cpol_q);
    assign last_tog    = (tog_left == TOG_W'(1));
    assign busy        = (state != IDLE);

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        toggle_en  = 1'b0;
        present_en = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: if (tick) begin
                       state_nxt = SHIFT;
                       toggle_en = 1'b1;
                   end
            SHIFT: if (tick) begin
                       toggle_en = 1'b1;
                       if (last_tog) state_nxt = HOLD;
                   end
            HOLD:  if (tick) begin
                       state_nxt = IDLE;
                       frame_end = 1'b1;
                   end
        endcase
        // CPHA=0 preloads the first bit, so the final trailing edge has nothing left to present.
        if (toggle_en) present_en = cpha_q ? leading : (!leading && !last_tog);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q     <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_cnt  <= '0;
            tog_left <= '0;
            sreg     <= '0;
            SPI_clk  <= 1'b0;
            DataBit  <= 1'b0;
            CS       <= '1;
            done     <= 1'b0;
        end else begin
            ld_q <= ld;
            done <= 1'b0;
            if (start) begin
                cpol_q   <= mode[1];
                cpha_q   <= mode[0];
                SPI_clk  <= mode[1];
                div_cnt  <= DIV_LOAD;
                tog_left <= TOG_LOAD;
                CS       <= cs_dec;
                if (!mode[0]) begin
                    DataBit <= head_bit(frame);
                    sreg    <= advance(frame);
                end else begin
                    sreg    <= frame;
                end
            end else if (state != IDLE) begin
                div_cnt <= tick ? DIV_LOAD : div_cnt - 1'b1;
                if (toggle_en) begin
                    SPI_clk  <= ~SPI_clk;
                    tog_left <= tog_left - 1'b1;
                end
                if (present_en) begin
                    DataBit <= head_bit(sreg);
                    sreg    <= advance(sreg);
                end
                if (frame_end) begin
                    CS   <= '1;
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_SER_MISO_EN
    logic               sample_en;
    logic [FRAME_W-1:0] rx_sh;
    logic [FRAME_W-1:0] rx_nxt;

    assign sample_en = toggle_en & (cpha_q ? ~leading : leading);

    always_comb begin
        if (MSB_FIRST != 0) begin
            rx_nxt    = rx_sh << 1;
            rx_nxt[0] = MISO;
        end else begin
            rx_nxt            = rx_sh >> 1;
            rx_nxt[FRAME_W-1] = MISO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sh   <= '0;
            rx_data <= '0;
        end else begin
            if (sample_en) rx_sh <= rx_nxt;
            if (frame_end) rx_data <= rx_sh;
        end
    end
`endif

endmodule
